// File: rtl/can_tx_opb_master.sv
// can_tx_opb_master: turns one CAN TX frame into OPB writes, then polls status until done or timeout
module can_tx_opb_master #(
  parameter logic [31:0] TXB_BASE  = 32'h0000_0100,
  parameter logic [31:0] STAT_ADDR = 32'h0000_0000,
  parameter int          BUSY_BIT  = 0,
  parameter int          POLL_MAX  = 1000
) (
  input  logic        OPB_CLK,
  input  logic        OPB_RST,
  input  logic        FRM_VALID,
  output logic        FRM_READY,
  input  logic [31:0] FRM_ID,
  input  logic [3:0]  FRM_DLC,
  input  logic [63:0] FRM_DATA,
  output logic [31:0] OPB_ADDR,
  output logic [31:0] OPB_WDATA,
  input  logic [31:0] OPB_RDATA,
  output logic        OPB_WE,
  output logic        OPB_RE,
  output logic        TX_BUSY,
  output logic        TX_DONE,
  output logic        TX_ERR
);
  typedef enum logic [3:0] {
    IDLE, WR_ID, G_ID, WR_DH, G_DH, WR_DL, G_DL, WR_CMD,
    G_CMD, RD_STAT, RD_WAIT, CHK, DONE, WR_ABT, G_ABT, ERR
  } state_t;
  localparam logic [15:0] PMAX = 16'(POLL_MAX);
  state_t      state_q;
  logic [31:0] id_q, addr_q, wdata_q;
  logic [63:0] data_q;
  logic [3:0]  dlc_q;
  logic [15:0] poll_q;
  logic        busy_bit_q, we_q, re_q, rdy_q, busy_q, done_q, err_q;
  logic [3:0]  dlc_c;
  assign dlc_c = dlc_q[3] ? 4'd8 : dlc_q;
  always_ff @(posedge OPB_CLK or posedge OPB_RST) begin
    if (OPB_RST) begin
      state_q    <= IDLE;
      id_q       <= '0;
      data_q     <= '0;
      dlc_q      <= '0;
      poll_q     <= '0;
      busy_bit_q <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      we_q       <= 1'b0;
      re_q       <= 1'b0;
      rdy_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      we_q   <= 1'b0;
      re_q   <= 1'b0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          rdy_q <= 1'b1;
          if (FRM_VALID && rdy_q) begin
            id_q    <= FRM_ID;
            dlc_q   <= FRM_DLC;
            data_q  <= FRM_DATA;
            poll_q  <= '0;
            rdy_q   <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= WR_ID;
            we_q    <= 1'b1;
            addr_q  <= TXB_BASE + 32'h4;
            wdata_q <= FRM_ID;
          end
        end
        WR_ID: state_q <= G_ID;
        G_ID: begin
          state_q <= WR_DH;
          we_q    <= 1'b1;
          addr_q  <= TXB_BASE + 32'h8;
          wdata_q <= data_q[63:32];
        end
        WR_DH: state_q <= G_DH;
        G_DH: begin
          state_q <= WR_DL;
          we_q    <= 1'b1;
          addr_q  <= TXB_BASE + 32'hC;
          wdata_q <= data_q[31:0];
        end
        WR_DL: state_q <= G_DL;
        G_DL: begin
          state_q <= WR_CMD;
          we_q    <= 1'b1;
          addr_q  <= TXB_BASE;
          wdata_q <= {12'h0, dlc_c, 15'h0, 1'b1};
        end
        WR_CMD: state_q <= G_CMD;
        G_CMD: begin
          state_q <= RD_STAT;
          re_q    <= 1'b1;
          addr_q  <= STAT_ADDR;
          poll_q  <= poll_q + 16'd1;
        end
        RD_STAT: state_q <= RD_WAIT;
        RD_WAIT: begin
          busy_bit_q <= |(OPB_RDATA & (32'd1 << BUSY_BIT));
          state_q    <= CHK;
        end
        CHK: begin
          if (!busy_bit_q) begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end else if (poll_q < PMAX) begin
            state_q <= RD_STAT;
            re_q    <= 1'b1;
            addr_q  <= STAT_ADDR;
            poll_q  <= poll_q + 16'd1;
          end else begin
            state_q <= WR_ABT;
            we_q    <= 1'b1;
            addr_q  <= TXB_BASE;
            wdata_q <= 32'h0000_0002;
          end
        end
        DONE, ERR: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          rdy_q   <= 1'b1;
        end
        WR_ABT: state_q <= G_ABT;
        G_ABT: begin
          state_q <= ERR;
          err_q   <= 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign FRM_READY = rdy_q;
  assign OPB_ADDR  = addr_q;
  assign OPB_WDATA = wdata_q;
  assign OPB_WE    = we_q;
  assign OPB_RE    = re_q;
  assign TX_BUSY   = busy_q;
  assign TX_DONE   = done_q;
  assign TX_ERR    = err_q;
endmodule

// File: tb/tb_can_tx_opb_master.sv
// tb_can_tx_opb_master: directed frames against hand-computed OPB access sequences and pulse timing
module tb_can_tx_opb_master;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        frm_valid = 1'b0;
  logic        frm_ready;
  logic [31:0] frm_id = '0;
  logic [3:0]  frm_dlc = '0;
  logic [63:0] frm_data = '0;
  logic [31:0] opb_addr, opb_wdata;
  logic [31:0] opb_rdata = '0;
  logic        opb_we, opb_re, tx_busy, tx_done, tx_err;
  int n_chk = 0, n_pass = 0;
  logic [31:0] w_addr[8], w_data[8];
  int w_cyc[8];
  int nw, nr, re_cyc, done_cyc, err_cyc, ndone, nerr, overlap;
  logic [31:0] r_addr;
  logic busy_first, busy_end, rdy_after, err_after;

  can_tx_opb_master #(.POLL_MAX(4)) dut (
    .OPB_CLK(clk), .OPB_RST(rst), .FRM_VALID(frm_valid), .FRM_READY(frm_ready),
    .FRM_ID(frm_id), .FRM_DLC(frm_dlc), .FRM_DATA(frm_data),
    .OPB_ADDR(opb_addr), .OPB_WDATA(opb_wdata), .OPB_RDATA(opb_rdata),
    .OPB_WE(opb_we), .OPB_RE(opb_re), .TX_BUSY(tx_busy), .TX_DONE(tx_done), .TX_ERR(tx_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic run_frame(input logic [31:0] id, input logic [3:0] dlc, input logic [63:0] data,
                           input int busy_n);
    nw = 0; nr = 0; re_cyc = 0; done_cyc = 0; err_cyc = 0; ndone = 0; nerr = 0; overlap = 0;
    r_addr = '1; busy_first = 1'b0; busy_end = 1'b0;
    @(negedge clk);
    frm_valid = 1'b1; frm_id = id; frm_dlc = dlc; frm_data = data;
    @(posedge clk);
    for (int c = 1; c <= 200 && ndone + nerr == 0; c++) begin
      @(negedge clk);
      frm_valid = 1'b0; frm_id = '1; frm_dlc = '0; frm_data = '0;
      if (c == 1) busy_first = tx_busy;
      if (opb_we && opb_re) overlap++;
      if (opb_we) begin
        if (nw < 8) begin
          w_addr[nw] = opb_addr; w_data[nw] = opb_wdata; w_cyc[nw] = c;
        end
        nw++;
      end
      if (opb_re) begin
        if (nr == 0) re_cyc = c;
        r_addr = opb_addr;
        nr++;
        opb_rdata = (nr <= busy_n) ? 32'h1 : 32'h0;
      end
      if (tx_done) begin ndone++; done_cyc = c; busy_end = tx_busy; end
      if (tx_err) begin nerr++; err_cyc = c; busy_end = tx_busy; end
    end
    chk("frame_terminated", 64'(ndone + nerr), 64'd1);
    @(negedge clk);
    rdy_after = frm_ready;
    err_after = tx_err;
  endtask

  task automatic check_writes(input string tag, input logic [31:0] id, input logic [63:0] data,
                              input logic [31:0] cmd);
    logic [31:0] ea[4];
    logic [31:0] ed[4];
    ea[0] = 32'h104; ea[1] = 32'h108; ea[2] = 32'h10C; ea[3] = 32'h100;
    ed[0] = id; ed[1] = data[63:32]; ed[2] = data[31:0]; ed[3] = cmd;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("%s_wr%0d", tag, i), {w_addr[i], w_data[i]}, {ea[i], ed[i]});
      chk($sformatf("%s_wcyc%0d", tag, i), 64'(w_cyc[i]), 64'(2 * i + 1));
    end
  endtask

  initial begin
    #2 rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_addr_wdata", {opb_addr, opb_wdata}, 64'h0);
    chk("rst_strobes", {opb_we, opb_re, frm_ready, tx_busy, tx_done, tx_err}, 64'h0);
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("ready_after_rst", frm_ready, 1'b1);
    chk("no_strobe_after_rst", {opb_we, opb_re}, 2'b00);

    run_frame(32'h1234_5678, 4'd8, 64'hAABBCCDD_11223344, 0);
    check_writes("basic", 32'h1234_5678, 64'hAABBCCDD_11223344, 32'h0008_0001);
    chk("basic_nw", 64'(nw), 64'd4);
    chk("basic_nr", 64'(nr), 64'd1);
    chk("basic_raddr", r_addr, 32'h0);
    chk("basic_re_cyc", 64'(re_cyc), 64'd9);
    chk("basic_done_cyc", 64'(done_cyc), 64'd12);
    chk("basic_nerr", 64'(nerr), 64'd0);
    chk("basic_busy_span", {busy_first, busy_end}, 2'b11);
    chk("basic_ready_after", rdy_after, 1'b1);
    chk("basic_overlap", 64'(overlap), 64'd0);

    run_frame(32'h0000_07FF, 4'd15, 64'h0102030405060708, 0);
    check_writes("dlc15", 32'h0000_07FF, 64'h0102030405060708, 32'h0008_0001);

    run_frame(32'h8000_0001, 4'd3, 64'hDEADBEEF_CAFEF00D, 0);
    chk("dlc3_cmd", w_data[3], 32'h0003_0001);

    run_frame(32'h1111_2222, 4'd2, 64'h0, 3);
    chk("poll3_nr", 64'(nr), 64'd4);
    chk("poll3_done_cyc", 64'(done_cyc), 64'd21);
    chk("poll3_nerr", 64'(nerr), 64'd0);
    chk("poll3_overlap", 64'(overlap), 64'd0);

    run_frame(32'h3333_4444, 4'd1, 64'h5555_6666_7777_8888, 99);
    chk("to_nr", 64'(nr), 64'd4);
    chk("to_nw", 64'(nw), 64'd5);
    chk("to_abort_wr", {w_addr[4], w_data[4]}, {32'h100, 32'h2});
    chk("to_abort_cyc", 64'(w_cyc[4]), 64'd21);
    chk("to_err_cyc", 64'(err_cyc), 64'd23);
    chk("to_ndone", 64'(ndone), 64'd0);
    chk("to_err_single", err_after, 1'b0);
    chk("to_ready_after", rdy_after, 1'b1);

    @(negedge clk);
    frm_valid = 1'b1; frm_id = 32'h9999_AAAA; frm_dlc = 4'd4; frm_data = 64'h1;
    @(posedge clk);
    repeat (3) @(negedge clk);
    frm_valid = 1'b0;
    chk("mid_dh_we", {opb_we, opb_addr}, {1'b1, 32'h108});
    rst = 1'b1;
    #1;
    chk("mid_rst_async", {opb_we, opb_re, tx_busy, frm_ready}, 4'b0000);
    ndone = 0; nerr = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (tx_done) ndone++;
      if (tx_err) nerr++;
    end
    chk("mid_no_pulse", 64'(ndone + nerr), 64'd0);
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("mid_ready", frm_ready, 1'b1);
    run_frame(32'h1234_5678, 4'd8, 64'hAABBCCDD_11223344, 0);
    check_writes("post_rst", 32'h1234_5678, 64'hAABBCCDD_11223344, 32'h0008_0001);
    chk("post_rst_done_cyc", 64'(done_cyc), 64'd12);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
